// File: rtl/logic_unit_pipe.sv
// Pipelined bitwise logic unit: STAGES-deep ready/valid pipeline with zero/parity/err flags.
// Each stage stalls independently, so bubbles are squeezed out under backpressure.
module logic_unit_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] opA,
  input  logic [WIDTH-1:0] opB,
  input  logic [3:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result_out,
  output logic             zero_out,
  output logic             parity_out,
  output logic             err_out,
  output logic             busy
);

  typedef struct packed {
    logic [WIDTH-1:0] res;
    logic             zero;
    logic             parity;
    logic             err;
  } beat_t;

  beat_t             calc_d;
  logic [WIDTH-1:0]  res_d;
  logic              err_d;

  always_comb begin
    res_d = '0;
    err_d = 1'b0;
    case (op)
      4'd0:    res_d = opA ^ opB;
      4'd1:    res_d = opA | opB;
      4'd2:    res_d = opA & opB;
      4'd3:    res_d = ~(opA | opB);
      4'd4:    res_d = ~(opA & opB);
      4'd5:    res_d = ~(opA ^ opB);
      4'd6:    res_d = opA & ~opB;
      4'd7:    res_d = opA;
      default: err_d = 1'b1;
    endcase
    calc_d.res    = res_d;
    calc_d.zero   = (res_d == '0);
    calc_d.parity = ^res_d;
    calc_d.err    = err_d;
  end

  logic [STAGES-1:0] valid_q;
  beat_t             stage_q [STAGES];
  logic [STAGES:0]   ready;
  logic [STAGES-1:0] up_valid;
  beat_t             up_data [STAGES];

  // Ready ripples from the consumer back to the input, one stage at a time.
  always_comb begin
    ready         = '0;
    ready[STAGES] = out_ready;
    for (int k = STAGES - 1; k >= 0; k--) begin
      ready[k] = !valid_q[k] || ready[k+1];
    end
  end

  genvar gi;
  generate
    for (gi = 0; gi < STAGES; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign up_valid[gi] = in_valid;
        assign up_data[gi]  = calc_d;
      end else begin : g_body
        assign up_valid[gi] = valid_q[gi-1];
        assign up_data[gi]  = stage_q[gi-1];
      end
    end
  endgenerate

  // Data only loads with a valid beat, so an emptied output keeps its last value.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= '0;
      for (int k = 0; k < STAGES; k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      for (int k = 0; k < STAGES; k++) begin
        if (ready[k]) begin
          valid_q[k] <= up_valid[k];
          if (up_valid[k]) begin
            stage_q[k] <= up_data[k];
          end
        end
      end
    end
  end

  assign in_ready   = ready[0];
  assign out_valid  = valid_q[STAGES-1];
  assign result_out = stage_q[STAGES-1].res;
  assign zero_out   = stage_q[STAGES-1].zero;
  assign parity_out = stage_q[STAGES-1].parity;
  assign err_out    = stage_q[STAGES-1].err;
  assign busy       = |valid_q;

endmodule

// File: tb/tb_logic_unit_pipe.sv
// Directed bench for logic_unit_pipe across four parameter sets sharing clk and rst_n.
module tb_logic_unit_pipe;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  // WIDTH=32, STAGES=2
  logic        a_in_valid = 1'b0, a_out_ready = 1'b1;
  logic        a_in_ready, a_out_valid, a_zero, a_parity, a_err, a_busy;
  logic [31:0] a_opA = '0, a_opB = '0, a_result;
  logic [3:0]  a_op = '0;
  // WIDTH=32, STAGES=4
  logic        f_in_valid = 1'b0, f_out_ready = 1'b1;
  logic        f_in_ready, f_out_valid, f_zero, f_parity, f_err, f_busy;
  logic [31:0] f_opA = '0, f_opB = '0, f_result;
  logic [3:0]  f_op = '0;
  // WIDTH=8, STAGES=1
  logic        n_in_valid = 1'b0, n_out_ready = 1'b1;
  logic        n_in_ready, n_out_valid, n_zero, n_parity, n_err, n_busy;
  logic [7:0]  n_opA = '0, n_opB = '0, n_result;
  logic [3:0]  n_op = '0;
  // WIDTH=64, STAGES=1
  logic        w_in_valid = 1'b0, w_out_ready = 1'b1;
  logic        w_in_ready, w_out_valid, w_zero, w_parity, w_err, w_busy;
  logic [63:0] w_opA = '0, w_opB = '0, w_result;
  logic [3:0]  w_op = '0;

  logic_unit_pipe #(.WIDTH(32), .STAGES(2)) u_dut (
    .clk(clk), .rst_n(rst_n), .in_valid(a_in_valid), .in_ready(a_in_ready),
    .opA(a_opA), .opB(a_opB), .op(a_op), .out_valid(a_out_valid), .out_ready(a_out_ready),
    .result_out(a_result), .zero_out(a_zero), .parity_out(a_parity), .err_out(a_err), .busy(a_busy));

  logic_unit_pipe #(.WIDTH(32), .STAGES(4)) u_dut4 (
    .clk(clk), .rst_n(rst_n), .in_valid(f_in_valid), .in_ready(f_in_ready),
    .opA(f_opA), .opB(f_opB), .op(f_op), .out_valid(f_out_valid), .out_ready(f_out_ready),
    .result_out(f_result), .zero_out(f_zero), .parity_out(f_parity), .err_out(f_err), .busy(f_busy));

  logic_unit_pipe #(.WIDTH(8), .STAGES(1)) u_dut8 (
    .clk(clk), .rst_n(rst_n), .in_valid(n_in_valid), .in_ready(n_in_ready),
    .opA(n_opA), .opB(n_opB), .op(n_op), .out_valid(n_out_valid), .out_ready(n_out_ready),
    .result_out(n_result), .zero_out(n_zero), .parity_out(n_parity), .err_out(n_err), .busy(n_busy));

  logic_unit_pipe #(.WIDTH(64), .STAGES(1)) u_dut64 (
    .clk(clk), .rst_n(rst_n), .in_valid(w_in_valid), .in_ready(w_in_ready),
    .opA(w_opA), .opB(w_opB), .op(w_op), .out_valid(w_out_valid), .out_ready(w_out_ready),
    .result_out(w_result), .zero_out(w_zero), .parity_out(w_parity), .err_out(w_err), .busy(w_busy));

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #2;
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid: got %b expected 0", a_out_valid); end
    checks++; if (a_result !== 32'h0) begin failures++; $display("FAIL reset_result: got %h expected 0", a_result); end
    checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL reset_busy: got %b expected 0", a_busy); end
    checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready: got %b expected 1", a_in_ready); end
    step();
    step();
    rst_n = 1'b1;
    a_out_ready = 1'b0;
    a_in_valid = 1'b1;
    a_op = 4'd7;
    a_opA = 32'h1111_1111;
    step();
    a_opA = 32'h2222_2222;
    step();
    a_in_valid = 1'b0;
    checks++; if (a_out_valid !== 1'b1 || a_result !== 32'h1111_1111) begin
      failures++; $display("FAIL prereset_inflight: got valid=%b result=%h expected valid=1 result=11111111", a_out_valid, a_result); end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL midreset_out_valid: got %b expected 0", a_out_valid); end
    checks++; if (a_result !== 32'h0) begin failures++; $display("FAIL midreset_result: got %h expected 0", a_result); end
    checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL midreset_busy: got %b expected 0", a_busy); end
    checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL midreset_in_ready: got %b expected 1", a_in_ready); end
    step();
    rst_n = 1'b1;
    a_out_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin
      step();
      checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL flushed_beat: cycle %0d got out_valid=%b expected 0", c, a_out_valid); end
    end
  endtask

  task automatic test_op_sweep();
    logic [31:0] exp_res [8] = '{32'hFF00_12CB, 32'hFFF0_12FF, 32'h00F0_0034, 32'h000F_ED00,
                                  32'hFF0F_FFCB, 32'h00FF_ED34, 32'hF000_1200, 32'hF0F0_1234};
    a_out_ready = 1'b1;
    a_opA = 32'hF0F0_1234;
    a_opB = 32'h0FF0_00FF;
    for (int c = 0; c <= 9; c++) begin
      if (c < 8) begin
        a_in_valid = 1'b1;
        a_op = 4'(c);
        checks++; if (a_in_ready !== 1'b1) begin failures++; $display("FAIL sweep_in_ready: op %0d got %b expected 1", c, a_in_ready); end
      end else begin
        a_in_valid = 1'b0;
      end
      step();
      if (c >= 1 && c <= 8) begin
        $display("sweep op=%0d valid=%b result=%h", c - 1, a_out_valid, a_result);
        checks++; if (a_out_valid !== 1'b1) begin failures++; $display("FAIL sweep_valid: op %0d got %b expected 1", c - 1, a_out_valid); end
        checks++; if (a_result !== exp_res[c-1]) begin failures++; $display("FAIL sweep_result: op %0d got %h expected %h", c - 1, a_result, exp_res[c-1]); end
        checks++; if (a_parity !== ^exp_res[c-1] || a_err !== 1'b0) begin
          failures++; $display("FAIL sweep_flags: op %0d got parity=%b err=%b expected parity=%b err=0", c - 1, a_parity, a_err, ^exp_res[c-1]); end
      end else begin
        checks++; if (a_out_valid !== 1'b0) begin failures++; $display("FAIL sweep_idle_valid: cycle %0d got %b expected 0", c, a_out_valid); end
      end
    end
  endtask

  task automatic test_flags();
    logic [31:0] va [5] = '{32'h5555_5555, 32'h5555_5555, 32'h0000_0001, 32'hFFFF_FFFF, 32'h0000_000F};
    logic [31:0] vb [5] = '{32'h5555_5555, 32'h5555_5555, 32'h0000_0000, 32'h0000_0000, 32'h0000_0003};
    logic [3:0]  vo [5] = '{4'd0, 4'd9, 4'd7, 4'd15, 4'd6};
    logic [31:0] vr [5] = '{32'h0, 32'h0, 32'h1, 32'h0, 32'hC};
    logic        vz [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    logic        vp [5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic        ve [5] = '{1'b0, 1'b1, 1'b0, 1'b1, 1'b0};
    a_out_ready = 1'b1;
    for (int v = 0; v < 5; v++) begin
      int n;
      a_opA = va[v];
      a_opB = vb[v];
      a_op = vo[v];
      a_in_valid = 1'b1;
      step();
      a_in_valid = 1'b0;
      n = 0;
      while (!a_out_valid && n < 5) begin
        step();
        n++;
      end
      $display("flags op=%0d result=%h zero=%b parity=%b err=%b", vo[v], a_result, a_zero, a_parity, a_err);
      checks++; if (a_out_valid !== 1'b1) begin failures++; $display("FAIL flags_timeout: vector %0d got out_valid=%b expected 1", v, a_out_valid); end
      checks++; if (a_result !== vr[v]) begin failures++; $display("FAIL flags_result: vector %0d got %h expected %h", v, a_result, vr[v]); end
      checks++; if (a_zero !== vz[v]) begin failures++; $display("FAIL flags_zero: vector %0d got %b expected %b", v, a_zero, vz[v]); end
      checks++; if (a_parity !== vp[v]) begin failures++; $display("FAIL flags_parity: vector %0d got %b expected %b", v, a_parity, vp[v]); end
      checks++; if (a_err !== ve[v]) begin failures++; $display("FAIL flags_err: vector %0d got %b expected %b", v, a_err, ve[v]); end
    end
    step();
  endtask

  task automatic test_backpressure();
    logic        exp_rdy [9] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1};
    int          next_in = 0;
    int          next_out = 0;
    logic        stalled = 1'b0;
    logic [31:0] held = '0;
    a_op = 4'd7;
    a_opB = '0;
    for (int c = 0; c < 16; c++) begin
      logic acc, dlv;
      a_out_ready = !(c >= 3 && c <= 7);
      a_in_valid = (next_in < 6);
      a_opA = 32'h100 + 32'(next_in);
      #1;
      if (c <= 8) begin
        checks++; if (a_in_ready !== exp_rdy[c]) begin failures++; $display("FAIL bp_in_ready: cycle %0d got %b expected %b", c, a_in_ready, exp_rdy[c]); end
      end
      if (stalled) begin
        checks++; if (a_out_valid !== 1'b1 || a_result !== held) begin
          failures++; $display("FAIL bp_hold: cycle %0d got valid=%b result=%h expected valid=1 result=%h", c, a_out_valid, a_result, held); end
      end
      acc = a_in_valid && a_in_ready;
      dlv = a_out_valid && a_out_ready;
      if (dlv) begin
        $display("bp deliver cycle=%0d result=%h", c, a_result);
        checks++; if (a_result !== 32'h100 + 32'(next_out)) begin
          failures++; $display("FAIL bp_order: beat %0d got %h expected %h", next_out, a_result, 32'h100 + 32'(next_out)); end
        next_out++;
      end
      stalled = a_out_valid && !a_out_ready;
      held = a_result;
      step();
      if (acc) next_in++;
    end
    a_in_valid = 1'b0;
    a_out_ready = 1'b1;
    checks++; if (next_out !== 6) begin failures++; $display("FAIL bp_count: got %0d beats expected 6", next_out); end
    checks++; if (a_busy !== 1'b0) begin failures++; $display("FAIL bp_drained_busy: got %b expected 0", a_busy); end
  endtask

  task automatic test_full_pipe();
    int got = 0;
    f_out_ready = 1'b1;
    f_op = 4'd1;
    f_opB = 32'h8000_0000;
    for (int c = 0; c < 25; c++) begin
      if (c < 20) begin
        f_in_valid = 1'b1;
        f_opA = 32'(c);
        checks++; if (f_in_ready !== 1'b1) begin failures++; $display("FAIL full_in_ready: cycle %0d got %b expected 1", c, f_in_ready); end
      end else begin
        f_in_valid = 1'b0;
      end
      step();
      if (c >= 3 && c <= 22) begin
        checks++; if (f_out_valid !== 1'b1) begin failures++; $display("FAIL full_valid: cycle %0d got %b expected 1", c, f_out_valid); end
        checks++; if (f_result !== (32'(c - 3) | 32'h8000_0000)) begin
          failures++; $display("FAIL full_result: cycle %0d got %h expected %h", c, f_result, 32'(c - 3) | 32'h8000_0000); end
        if (f_out_valid) got++;
      end else begin
        checks++; if (f_out_valid !== 1'b0) begin failures++; $display("FAIL full_idle_valid: cycle %0d got %b expected 0", c, f_out_valid); end
      end
    end
    $display("full pipe delivered %0d beats", got);
    checks++; if (got !== 20) begin failures++; $display("FAIL full_count: got %0d expected 20", got); end
  endtask

  task automatic test_corners();
    n_opA = 8'hA5;
    n_opB = 8'hFF;
    n_op = 4'd3;
    n_in_valid = 1'b1;
    #1;
    checks++; if (n_in_ready !== 1'b1) begin failures++; $display("FAIL w8_in_ready: got %b expected 1", n_in_ready); end
    step();
    n_in_valid = 1'b0;
    $display("w8 nor result=%h zero=%b", n_result, n_zero);
    checks++; if (n_out_valid !== 1'b1) begin failures++; $display("FAIL w8_valid: got %b expected 1", n_out_valid); end
    checks++; if (n_result !== 8'h00 || n_zero !== 1'b1 || n_err !== 1'b0) begin
      failures++; $display("FAIL w8_result: got %h zero=%b err=%b expected 00 zero=1 err=0", n_result, n_zero, n_err); end
    step();
    checks++; if (n_out_valid !== 1'b0) begin failures++; $display("FAIL w8_drain: got %b expected 0", n_out_valid); end

    w_opA = {64{1'b1}};
    w_opB = {64{1'b1}};
    w_op = 4'd2;
    w_in_valid = 1'b1;
    step();
    w_in_valid = 1'b0;
    $display("w64 and result=%h zero=%b parity=%b", w_result, w_zero, w_parity);
    checks++; if (w_out_valid !== 1'b1) begin failures++; $display("FAIL w64_valid: got %b expected 1", w_out_valid); end
    checks++; if (w_result !== 64'hFFFF_FFFF_FFFF_FFFF) begin failures++; $display("FAIL w64_result: got %h expected ffffffffffffffff", w_result); end
    checks++; if (w_zero !== 1'b0 || w_parity !== 1'b0) begin
      failures++; $display("FAIL w64_flags: got zero=%b parity=%b expected zero=0 parity=0", w_zero, w_parity); end
    step();
  endtask

  initial begin
    test_reset();
    test_op_sweep();
    test_flags();
    test_backpressure();
    test_full_pipe();
    test_corners();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation still running at time limit");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/logic_unit_pipe.md
Name: logic_unit_pipe

Overview:
Parametrised, pipelined successor to the single-cycle 32-bit logic unit. It performs bitwise logic operations on two WIDTH-bit operands, with a selectable operation set and status flags. A ready/valid handshake with full backpressure runs at one result per clock. It sits in the execute path beside the adder and shifter and feeds the writeback mux.

Parameters:
WIDTH, 32, operand and result width in bits; legal range 8..64.
STAGES, 2, pipeline depth = input-to-output latency in cycles; legal range 1..4.

Ports:
clk  input  1  single clock, all state on rising edge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operand beat offered
in_ready  output  1  unit accepts beat this cycle
opA  input  WIDTH  operand A
opB  input  WIDTH  operand B
op  input  4  operation select
out_valid  output  1  result beat available
out_ready  input  1  consumer accepts result this cycle
result_out  output  WIDTH  operation result
zero_out  output  1  result_out == 0
parity_out  output  1  XOR-reduction of result_out
err_out  output  1  op was illegal for this beat
busy  output  1  any pipeline stage holds a valid beat

Behaviour:
- Reset: asynchronous; asserting rst_n low clears immediately, regardless of clk.
  - All stage valid bits go to 0.
  - result_out, zero_out, parity_out and err_out go to 0.
  - busy goes to 0.
  - in_ready goes to 1, because the pipeline is empty.
  - Deassertion is sampled on the next clk edge.
  - Reset mid-operation flushes every in-flight beat; flushed beats are never delivered.
- Op encoding (computed combinationally in stage 0, then registered):
  - 0 XOR: A^B
  - 1 OR: A|B
  - 2 AND: A&B
  - 3 NOR: ~(A|B)
  - 4 NAND: ~(A&B)
  - 5 XNOR: ~(A^B)
  - 6 ANDN: A&~B
  - 7 PASSA: A
  - 8..15 illegal: result = 0, err = 1
- Flags: zero and parity are computed on the stage-0 result and travel with it; err = 1 only for illegal ops.
- Accept: a beat is accepted on a rising edge when in_valid && in_ready.
- Pipeline: stage k (k = 0..STAGES-1) holds a valid bit plus data {result, zero, parity, err}.
  - Stage k may load when it is empty, or when its contents move on in the same cycle: ready_k = !valid_k || ready_{k+1}.
  - ready of the final stage is out_ready.
  - in_ready = ready_0, combinational from out_ready through the chain.
  - No combinational path from in_valid to out_valid.
- Latency and throughput:
  - Without stall, a beat accepted at edge N presents out_valid = 1 after edge N+STAGES-1. With STAGES=1, the output is registered directly by the accept edge.
  - Throughput is 1 beat per cycle while out_ready = 1.
- Backpressure:
  - While out_valid && !out_ready, result_out and all flags are held stable and out_valid stays 1.
  - Upstream stages compact into empty slots. A stage is never overwritten while it is valid and not moving.
- Ordering: results leave in accept order. There is no drop and no duplication.
- Simultaneous events: with a full pipeline, out_ready = 1 and in_valid = 1, one beat leaves and one enters on the same edge. The occupancy is unchanged and in_ready stays 1.
- Full: with all STAGES valid and out_ready = 0, in_ready = 0 and the input beat is not accepted. The source must hold opA, opB and op stable until it is accepted.
- Empty: out_valid = 0. The values of result_out and the flags are held from the last beat (0 after reset); consumers must ignore them.
- busy = OR of all stage valid bits.
- Width rule: all ops are bitwise on exactly WIDTH bits; no carries, no sign handling.

Test Plan:
- Reset state: hold rst_n = 0 mid-stream with 2 beats in flight, then release. Required: out_valid = 0, result_out = 0, busy = 0, in_ready = 1. No flushed beat appears afterwards.
- Op sweep: WIDTH=32, STAGES=2, out_ready = 1, A = 0xF0F0_1234, B = 0x0FF0_00FF, ops 0..7 on back-to-back cycles.
  - Required results: 0xFF00_12CB, 0xFFF0_12FF, 0x00F0_0034, 0x000F_ED00, 0xFF0F_FFCB, 0x00FF_ED34, 0xF000_1200, 0xF0F0_1234.
  - Each result appears 2 cycles after its accept, one per cycle.
- Flags and illegal op:
  - A = B = 0x5555_5555, op = 0 -> result 0, zero = 1, parity = 0, err = 0.
  - op = 9 -> result 0, zero = 1, err = 1.
  - A = 0x1, op = 7 -> zero = 0, parity = 1.
- Backpressure: stream 6 beats with out_ready = 0 for cycles 3..7, STAGES=2.
  - in_ready drops after 2 beats are held.
  - result_out stays stable while stalled.
  - All 6 beats are delivered in order with no loss.
- Full-pipe pass-through: STAGES=4, keep in_valid = 1 and out_ready = 1 for 20 cycles. Required: in_ready = 1 throughout and exactly 20 results, in order, after 4-cycle latency.
- Parameter corners: WIDTH=8, STAGES=1, A = 0xA5, B = 0xFF, op = 3 -> result 0x00, zero = 1, valid on the next cycle. Repeat with WIDTH=64 and all-ones operands, op = 2 -> 0xFFFF_FFFF_FFFF_FFFF.
